// File: rtl/sm_loader_pkg.sv
// Shared constants for the instruction-memory loader.
//   sync_byte  : first byte of every load frame
//   bcast_node : node byte that addresses every node at once
//   state_t    : loader FSM state encoding
package sm_loader_pkg;

  localparam logic [7:0] SYNC_BYTE  = 8'hA5;
  localparam logic [7:0] BCAST_NODE = 8'hFF;

  typedef enum logic [2:0] {
    S_SYNC   = 3'd0,
    S_NODE   = 3'd1,
    S_CNT_LO = 3'd2,
    S_CNT_HI = 3'd3,
    S_DATA   = 3'd4,
    S_CSUM   = 3'd5
  } state_t;

endpackage

// File: rtl/sm_imem_loader.sv
// sm_imem_loader: fills one node's writable instruction memory from a byte stream.
//
// Frame: A5, node, cnt_lo, cnt_hi, 4*cnt data bytes (little-endian words), csum
// where csum is the XOR of all data bytes. The node's core is held in reset
// until a frame addressed to it (node == NODE_ID or FF) completes with a good
// checksum.
//
// Byte stream handshake: a byte transfers on a rising edge where
// in_valid & in_ready are both 1. The source must hold in_data stable while
// in_valid=1 and in_ready=0. in_ready is 0 during reset, the first cycle after
// it, and in every imem_we cycle.
//
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   in_valid   byte stream valid
//   in_data    byte stream data
//   in_ready   loader accepts a byte this cycle
//   imem_we    one-cycle write strobe per completed word
//   imem_addr  word address (0, 1, 2, ... within a frame)
//   imem_wd    word data
//   cpu_hold   1 keeps this node's core in reset
//   load_done  one-cycle pulse after a good frame for this node
//   load_err   sticky error, cleared by the next sync byte
module sm_imem_loader
  import sm_loader_pkg::*;
#(
  parameter int SIZE    = 64,
  parameter int NODE_ID = 0,
  parameter int ADDR_W  = $clog2(SIZE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wd,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err
);

  localparam logic [15:0] SIZE16 = 16'(SIZE);
  localparam logic [7:0]  NODE8  = 8'(NODE_ID);

  state_t      state;
  logic        match;
  logic [7:0]  cnt_lo;
  logic [15:0] cnt;
  logic [15:0] word_cnt;
  logic [1:0]  byte_k;
  logic [31:0] shift;
  logic [7:0]  acc;

  logic        accept;
  logic        node_hit;
  logic [15:0] cnt_new;
  logic [31:0] word;

  assign accept   = in_valid & in_ready;
  assign node_hit = (in_data == NODE8) || (in_data == BCAST_NODE);
  assign cnt_new  = {in_data, cnt_lo};
  // Bytes enter at the top and shift down, so after three bytes shift[31:8]
  // holds b2:b1:b0 and the fourth byte completes the little-endian word.
  assign word     = {in_data, shift[31:8]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_SYNC;
      match     <= 1'b0;
      cnt_lo    <= 8'd0;
      cnt       <= 16'd0;
      word_cnt  <= 16'd0;
      byte_k    <= 2'd0;
      shift     <= 32'd0;
      acc       <= 8'd0;
      in_ready  <= 1'b0;
      imem_we   <= 1'b0;
      imem_addr <= '0;
      imem_wd   <= 32'd0;
      cpu_hold  <= 1'b1;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      imem_we   <= 1'b0;
      load_done <= 1'b0;
      in_ready  <= 1'b1;
      if (accept) begin
        case (state)
          S_SYNC: begin
            if (in_data == SYNC_BYTE) begin
              load_err <= 1'b0;
              state    <= S_NODE;
            end
          end
          S_NODE: begin
            match <= node_hit;
            if (node_hit) cpu_hold <= 1'b1;
            state <= S_CNT_LO;
          end
          S_CNT_LO: begin
            cnt_lo <= in_data;
            state  <= S_CNT_HI;
          end
          S_CNT_HI: begin
            cnt      <= cnt_new;
            word_cnt <= 16'd0;
            byte_k   <= 2'd0;
            acc      <= 8'd0;
            // Oversized frames are still consumed byte for byte so the
            // stream stays framed, but nothing is written.
            if (cnt_new > SIZE16) begin
              load_err <= 1'b1;
              match    <= 1'b0;
            end
            state <= (cnt_new == 16'd0) ? S_CSUM : S_DATA;
          end
          S_DATA: begin
            acc    <= acc ^ in_data;
            byte_k <= byte_k + 2'd1;
            shift  <= word;
            if (byte_k == 2'd3) begin
              if (match) begin
                imem_we   <= 1'b1;
                imem_addr <= word_cnt[ADDR_W-1:0];
                imem_wd   <= word;
                // Bubble: no byte is taken during the write cycle.
                in_ready  <= 1'b0;
              end
              word_cnt <= word_cnt + 16'd1;
              if (word_cnt + 16'd1 == cnt) state <= S_CSUM;
            end
          end
          S_CSUM: begin
            if (match) begin
              if (in_data == acc) begin
                load_done <= 1'b1;
                cpu_hold  <= 1'b0;
              end else begin
                load_err <= 1'b1;
              end
            end
            state <= S_SYNC;
          end
          default: state <= S_SYNC;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sm_imem_loader.sv
`timescale 1ns/1ps
module tb_sm_imem_loader;

  localparam int SIZE   = 64;
  localparam int ADDR_W = 6;

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wd;
  logic              cpu_hold;
  logic              load_done;
  logic              load_err;

  always #5 clk = ~clk;

  sm_imem_loader #(.SIZE(SIZE), .NODE_ID(0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wd(imem_wd), .cpu_hold(cpu_hold), .load_done(load_done),
    .load_err(load_err)
  );

  // ---------------- scoreboard ----------------
  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  int done_base = 0;
  int wr_cnt = 0;
  bit chk_rdy = 1'b0;
  logic [ADDR_W+31:0] exp_q[$];
  logic [31:0] word_buf[0:127];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Write monitor: every imem_we must match the next expected {addr, data}.
  always @(negedge clk) begin
    if (!rst && imem_we) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_write", {26'd0, imem_addr, imem_wd}, 64'd0);
      end else begin
        logic [ADDR_W+31:0] e;
        e = exp_q.pop_front();
        check("write_addr", {58'd0, imem_addr}, {58'd0, e[ADDR_W+31:32]});
        check("write_data", {32'd0, imem_wd}, {32'd0, e[31:0]});
      end
    end
    if (!rst && load_done) done_cnt++;
    // Outside reset, in_ready drops only for the write bubble.
    if (!rst && chk_rdy) check("ready_bubble", {63'd0, in_ready}, {63'd0, ~imem_we});
  end

  // ---------------- drivers ----------------
  // Entered and left at a negedge.
  task automatic send_byte(input logic [7:0] b, input bit toggle);
    bit sent;
    sent = 1'b0;
    in_valid = 1'b1;
    in_data  = b;
    for (int t = 0; t < 1000 && !sent; t++) begin
      if (in_ready) sent = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (!sent) check("byte_accept_timeout", 64'd0, 64'd1);
    if (toggle) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] node, input logic [15:0] cnt,
                            input bit bad, input bit exp_wr, input bit toggle);
    logic [7:0] acc;
    done_base = done_cnt;
    acc = 8'd0;
    send_byte(8'hA5, toggle);
    send_byte(node, toggle);
    send_byte(cnt[7:0], toggle);
    send_byte(cnt[15:8], toggle);
    for (int i = 0; i < int'(cnt); i++) begin
      if (exp_wr && cnt <= 16'(SIZE)) exp_q.push_back({ADDR_W'(i), word_buf[i]});
      for (int k = 0; k < 4; k++) begin
        acc = acc ^ word_buf[i][8*k +: 8];
        send_byte(word_buf[i][8*k +: 8], toggle);
      end
    end
    send_byte(bad ? (acc ^ 8'h5A) : acc, toggle);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_outcome(input string name, input bit done_exp,
                               input bit err_exp, input bit hold_exp);
    check({name, "_done"}, 64'(done_cnt - done_base), {63'd0, done_exp});
    check({name, "_err"}, {63'd0, load_err}, {63'd0, err_exp});
    check({name, "_hold"}, {63'd0, cpu_hold}, {63'd0, hold_exp});
    check({name, "_pending_writes"}, 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string       name;
    logic [7:0]  node;
    logic [15:0] cnt;
    logic [31:0] w0;
    logic [31:0] w1;
    bit          bad;
    bit          exp_wr;
    bit          exp_done;
    bit          exp_err;
    bit          exp_hold;
  } vec_t;

  vec_t tbl[7];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{"good_2w",     8'h00, 16'd2, 32'h00500293, 32'h00528293, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{"bad_csum",    8'h00, 16'd2, 32'h00500293, 32'h00528293, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[2] = '{"other_node",  8'h03, 16'd2, 32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{"bcast_1w",    8'hFF, 16'd1, 32'hDEADBEEF, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{"other_hold0", 8'h05, 16'd1, 32'hCAFEF00D, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{"cnt0_good",   8'h00, 16'd0, 32'h0,        32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{"cnt0_bad",    8'h00, 16'd0, 32'h0,        32'h0,        1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 8'd0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", {63'd0, in_ready}, 64'd0);
    check("rst_we", {63'd0, imem_we}, 64'd0);
    check("rst_hold", {63'd0, cpu_hold}, 64'd1);
    check("rst_done", {63'd0, load_done}, 64'd0);
    check("rst_err", {63'd0, load_err}, 64'd0);
    check("rst_addr_wd", {26'd0, imem_addr, imem_wd}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", {63'd0, in_ready}, 64'd1);
    chk_rdy = 1'b1;

    // Table-driven frames.
    for (int r = 0; r < 7; r++) begin
      word_buf[0] = tbl[r].w0;
      word_buf[1] = tbl[r].w1;
      send_frame(tbl[r].node, tbl[r].cnt, tbl[r].bad, tbl[r].exp_wr, 1'b0);
      check_outcome(tbl[r].name, tbl[r].exp_done, tbl[r].exp_err, tbl[r].exp_hold);
    end

    // Full-depth frame: addresses 0..SIZE-1.
    for (int i = 0; i < SIZE; i++) word_buf[i] = $urandom;
    wr_cnt = 0;
    send_frame(8'h00, 16'(SIZE), 1'b0, 1'b1, 1'b0);
    check_outcome("full_size", 1'b1, 1'b0, 1'b0);
    check("full_size_writes", 64'(wr_cnt), 64'(SIZE));

    // Oversized frame: error at CNT_HI, all bytes swallowed, no writes.
    wr_cnt = 0;
    done_base = done_cnt;
    send_byte(8'hA5, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'(SIZE + 1), 1'b0);
    send_byte(8'h00, 1'b0);
    check("oversize_err_at_cnt_hi", {63'd0, load_err}, 64'd1);
    for (int i = 0; i < 4 * (SIZE + 1); i++) send_byte(8'($urandom_range(0, 255)), 1'b0);
    send_byte(8'($urandom_range(0, 255)), 1'b0);
    repeat (3) @(negedge clk);
    check_outcome("oversize", 1'b0, 1'b1, 1'b1);
    check("oversize_writes", 64'(wr_cnt), 64'd0);

    // Garbage, then a 1-word frame with in_valid toggling; proves FSM is back in SYNC.
    wr_cnt = 0;
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    word_buf[0] = 32'($urandom);
    send_frame(8'h00, 16'd1, 1'b0, 1'b1, 1'b1);
    check_outcome("toggle_1w", 1'b1, 1'b0, 1'b0);
    check("toggle_writes", 64'(wr_cnt), 64'd1);

    // Reset after the second data byte.
    send_byte(8'hA5, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h77, 1'b0);
    send_byte(8'h66, 1'b0);
    chk_rdy = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", {63'd0, in_ready}, 64'd0);
    check("midrst_hold", {63'd0, cpu_hold}, 64'd1);
    check("midrst_we", {63'd0, imem_we}, 64'd0);
    check("midrst_err_done", {62'd0, load_err, load_done}, 64'd0);
    check("midrst_addr_wd", {26'd0, imem_addr, imem_wd}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk_rdy = 1'b1;
    word_buf[0] = 32'h00A00113;
    word_buf[1] = 32'h00000013;
    send_frame(8'h00, 16'd2, 1'b0, 1'b1, 1'b0);
    check_outcome("after_rst", 1'b1, 1'b0, 1'b0);

    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
